// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: reset/NOP constants, the IF/ID payload type and an alignment helper.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
  } ifid_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_pc_gen.sv
// PC register with next-PC selection: hold on stall, else redirect target or sequential pc+4.
module pc_gen
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (!stall_i) begin
      pc_d = redirect_i ? redirect_pc_i : pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage and IF/ID register with redirect, stall and branch-likely annul.
// Define FETCH_ADEL_EN to turn misaligned fetches into bubbles flagged on id_adel.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        annul_ds,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_adel
);

  logic [31:0] pc;
  ifid_t       ifid_q;
  ifid_t       ifid_d;
  logic        fetch_adel;

  pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_o          (pc)
  );

  assign imem_addr = word_align(pc);

`ifdef FETCH_ADEL_EN
  logic adel_q;

  assign fetch_adel = |pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adel_q <= 1'b0;
    end else if (!stall) begin
      adel_q <= fetch_adel;
    end
  end

  assign id_adel = adel_q;
`else
  assign fetch_adel = 1'b0;
  assign id_adel    = 1'b0;
`endif

  // Annul and address error both turn the slot into a bubble but keep its PC for the exception unit.
  always_comb begin
    ifid_d = ifid_q;
    if (!stall) begin
      ifid_d.pc  = pc;
      ifid_d.pc8 = pc + 32'd8;
      if (annul_ds || fetch_adel) begin
        ifid_d.inst  = NOP_INST;
        ifid_d.valid = 1'b0;
      end else begin
        ifid_d.inst  = imem_rdata;
        ifid_d.valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q <= '{inst: NOP_INST, pc: 32'd0, pc8: 32'd8, valid: 1'b0};
    end else begin
      ifid_q <= ifid_d;
    end
  end

  assign id_inst  = ifid_q.inst;
  assign id_pc    = ifid_q.pc;
  assign id_pc8   = ifid_q.pc8;
  assign id_valid = ifid_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized stall/redirect/annul traffic.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        annul_ds = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_valid;
  logic        id_adel;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;
  logic [31:0] m_pc8;
  logic        m_valid;
  logic        m_adel;

  if_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .annul_ds    (annul_ds),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_pc8      (id_pc8),
    .id_valid    (id_valid),
    .id_adel     (id_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2408_0001;
    return {a[15:0] ^ 16'hA5C3, a[31:16]} + 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc    = 32'h0000_3000;
    m_inst  = 32'd0;
    m_ipc   = 32'd0;
    m_pc8   = 32'd8;
    m_valid = 1'b0;
    m_adel  = 1'b0;
  endtask

  task automatic model_edge();
    logic bad;
`ifdef FETCH_ADEL_EN
    bad = (m_pc[1:0] != 2'b00);
`else
    bad = 1'b0;
`endif
    if (!stall) begin
      m_ipc   = m_pc;
      m_pc8   = m_pc + 32'd8;
      m_valid = !(annul_ds || bad);
      m_inst  = m_valid ? mem_word({m_pc[31:2], 2'b00}) : 32'd0;
      m_adel  = bad;
      m_pc    = redirect ? redirect_pc : m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".imem_addr"}, imem_addr, {m_pc[31:2], 2'b00});
    chk({where, ".id_inst"},   id_inst,   m_inst);
    chk({where, ".id_pc"},     id_pc,     m_ipc);
    chk({where, ".id_pc8"},    id_pc8,    m_pc8);
    chk({where, ".id_valid"},  {31'd0, id_valid}, {31'd0, m_valid});
    chk({where, ".id_adel"},   {31'd0, id_adel},  {31'd0, m_adel});
  endtask

  // Apply current inputs across one rising edge, then compare against the model.
  task automatic step(input string where);
    model_edge();
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rpc, input logic a);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    annul_ds    = a;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // first fetch from the reset vector
    drive(0, 0, 32'd0, 0);
    step("t1");
    chk("t1.inst_const", id_inst, 32'h2408_0001);
    chk("t1.pc8_const", id_pc8, 32'h0000_3008);
    step("t1b");

    // redirect keeps the delay slot
    drive(0, 1, 32'h0000_3100, 0);
    step("t2");
    chk("t2.ds_pc", id_pc, 32'h0000_3008);
    chk("t2.target", imem_addr, 32'h0000_3100);

    // stall with redirect pending holds everything
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h0000_3010, 0);
      step("t3.stall");
    end
    chk("t3.held_addr", imem_addr, 32'h0000_3100);
    drive(0, 1, 32'h0000_3010, 0);
    step("t3.release");

    // branch-likely annul
    drive(0, 0, 32'd0, 1);
    step("t4");
    chk("t4.valid0", {31'd0, id_valid}, 32'd0);
    chk("t4.pc", id_pc, 32'h0000_3010);

    // both asserted: annul for IF/ID, redirect for pc
    drive(0, 1, 32'hFFFF_FFFC, 1);
    step("both");

    // 32-bit wrap
    drive(0, 0, 32'd0, 0);
    step("t5");
    chk("t5.wrap_pc8", id_pc8, 32'h0000_0004);
    chk("t5.wrap_addr", imem_addr, 32'h0000_0000);

    // misaligned redirect target
    drive(0, 1, 32'h0000_3102, 0);
    step("t6.redir");
    drive(0, 0, 32'd0, 0);
    step("t6.fetch");
    chk("t6.pc", id_pc, 32'h0000_3102);
`ifdef FETCH_ADEL_EN
    chk("t6.adel", {31'd0, id_adel}, 32'd1);
`else
    chk("t6.noadel", {31'd0, id_adel}, 32'd0);
`endif
    step("t6.next");

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, tgt,
            $urandom_range(0, 9) == 0);
      step("rand");
    end

    // async reset in the middle of a stalled redirect
    drive(1, 1, 32'h0000_5000, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'd0, 0);
    step("after_reset");
    chk("after_reset.inst", id_inst, 32'h2408_0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
